issue_execute_fifo: RTL and testbench
=====================================

Name: issue_execute_fifo

Overview:
- Show-ahead (first-word-fall-through) FIFO between the issue stage and a single execute unit, e.g. the issue→mul path feeding the multiplier execute stage.
- Issue pushes one issue_execute_pack_t per cycle. The execute unit sees the head entry combinationally with a valid flag and pops it in the same cycle it consumes it.
- Supports a pipeline flush driven by the commit feedback flush.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- WIDTH, $bits(issue_execute_pack_t), entry width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- data_in  input  WIDTH  entry written on an accepted push.
- push  input  1  push request from issue.
- full  output  1  no free entry.
- data_out  output  WIDTH  head entry; all-zero when empty.
- data_out_valid  output  1  head entry present.
- pop  input  1  consume head entry.
- flush  input  1  discard all entries (commit flush).
- count  output  $clog2(DEPTH)+1  number of stored entries.

Behaviour:
- Storage: DEPTH×WIDTH array. It is not reset. Read/write pointers carry one extra wrap bit.
- Empty: rptr==wptr. Full: index bits equal and wrap bits differ.
- count = wptr − rptr, modulo 2^($clog2(DEPTH)+1).
- Reset (rst=0, asynchronous): rptr=wptr=0. Consequently full=0, data_out_valid=0, count=0, data_out=0. These values hold until the first rising edge after rst deasserts.
- Outputs:
  - full, data_out_valid and count are functions of the pointer registers only. They carry no combinational path from push, pop or flush.
  - data_out = mem[rptr index] when non-empty, else 0.
- Accepted push = push && !full. It writes data_in at wptr and increments wptr.
- Push while full: ignored. No write, no pointer change, no error flag.
- Accepted pop = pop && data_out_valid. It increments rptr.
- Pop while empty: ignored.
- Simultaneous accepted push and pop:
  - Both occur. count is unchanged.
  - When empty, push+pop pops nothing. The pushed entry becomes visible the next cycle; there is no combinational bypass.
  - When full, the push is rejected even if pop is asserted. full is registered-state based and must not depend on pop.
- Flush: rptr and wptr both go to 0 at the next edge. Flush has priority over push and pop in the same cycle: data_in is not retained, and the pop has no effect.
- Latency:
  - Push at edge N → data_out_valid=1 and data_out=data_in after edge N, when the FIFO was empty.
  - Pop at edge N → the next entry is presented after edge N.
- Wrap-around: pointer index wraps from DEPTH−1 to 0 and the wrap bit toggles. Ordering is strictly FIFO across wrap.
- Reset mid-operation: all entries are lost immediately. Outputs take reset values asynchronously.
- The execute-side contract (pop = valid && !flush) is the consumer's responsibility. The FIFO must still behave as above for any pop/push/flush pattern.
- Assertions (sim only): count ≤ DEPTH; never full && count≠DEPTH; never data_out_valid && count==0.

Test Plan (DEPTH=4, WIDTH=8):
- Reset then idle: rst=0 mid-cycle → full=0, data_out_valid=0, count=0, data_out=0 immediately. After rst=1 with no push/pop, these values persist for 5 cycles.
- Fill and overflow: push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles.
  - Required: full=1 and count=4 after the 4th push; 0x55 dropped.
  - Then pop 4 times: data_out sequence 0x11,0x22,0x33,0x44. Then data_out_valid=0 and data_out=0.
- Show-ahead and simultaneous ops:
  - Push 0xA1 → next cycle data_out=0xA1, valid=1.
  - Same cycle push 0xA2 + pop → data_out=0xA2, count=1.
  - Push+pop while empty → valid=1 with the pushed data one cycle later.
- Full with push+pop: with 4 entries, assert push(0x99)+pop → count=3, 0x99 not stored. The remaining three entries drain in order.
- Wrap-around: 10 push/pop pairs staggered so the pointers wrap twice, data 0x00..0x09 → popped sequence exactly 0x00..0x09, count never >4.
- Flush priority: with 3 entries, assert flush+push(0x77)+pop in one cycle → next cycle count=0, valid=0, full=0. A following push 0x88 appears as the head one cycle later.

Source files
------------

// File: rtl/issue_execute_fifo.sv
// -----------------------------------------------------------------------------
// issue_execute_fifo
//
// Show-ahead (first-word-fall-through) FIFO sitting between the issue stage and
// a single execute unit (e.g. issue -> multiplier). The head entry is presented
// combinationally with a valid flag; the consumer pops it in the same cycle it
// uses it. A commit-side flush empties the queue at the next clock edge.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   WIDTH  entry width in bits; instantiations pass $bits(issue_execute_pack_t)
//
// Ports:
//   clk             clock, all state updates on the rising edge
//   rst             asynchronous active-low reset
//   data_in         entry written on an accepted push
//   push            push request from issue
//   full            no free entry (pointer state only)
//   data_out        head entry, all-zero when empty
//   data_out_valid  head entry present (pointer state only)
//   pop             consume the head entry
//   flush           discard all entries, wins over push and pop
//   count           number of stored entries
// -----------------------------------------------------------------------------
module issue_execute_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     push,
    output logic                     full,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_out_valid,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
        $error("issue_execute_fifo: DEPTH must be a power of two and at least 2");
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      rptr_q, rptr_d;
    logic [AW:0]      wptr_q, wptr_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic empty;
    logic push_acc;
    logic pop_acc;

    // Status is derived from the pointer registers only, so there is no
    // combinational path from push/pop/flush to full, valid or count.
    always_comb begin
        empty          = (rptr_q == wptr_q);
        full           = (rptr_q[AW-1:0] == wptr_q[AW-1:0]) && (rptr_q[AW] != wptr_q[AW]);
        data_out_valid = !empty;
        count          = wptr_q - rptr_q;
        data_out       = empty ? '0 : mem[rptr_q[AW-1:0]];
    end

    // A full FIFO rejects a push even when a pop arrives in the same cycle.
    always_comb begin
        push_acc = push && !full && !flush;
        pop_acc  = pop && data_out_valid && !flush;
    end

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        if (flush) begin
            rptr_d = '0;
            wptr_d = '0;
        end else begin
            if (push_acc) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop_acc) begin
                rptr_d = rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
        end
    end

    // Storage is deliberately not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wptr_q[AW-1:0]] <= data_in;
        end
    end

    assert property (@(posedge clk) disable iff (!rst) count <= DepthCnt);
    assert property (@(posedge clk) disable iff (!rst) !(full && count != DepthCnt));
    assert property (@(posedge clk) disable iff (!rst) !(data_out_valid && count == '0));

endmodule

// File: tb/tb_issue_execute_fifo.sv
module tb_issue_execute_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             push;
    logic             full;
    logic [WIDTH-1:0] data_out;
    logic             data_out_valid;
    logic             pop;
    logic             flush;
    logic [2:0]       count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_q [$];
    logic [7:0] popped  [$];

    typedef struct {
        logic       push;
        logic [7:0] din;
        logic       pop;
        logic       flush;
        logic       exp_valid;
        logic [7:0] exp_dout;
        logic [2:0] exp_count;
        logic       exp_full;
    } vec_t;

    vec_t vecs [$];

    issue_execute_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .push           (push),
        .full           (full),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .pop            (pop),
        .flush          (flush),
        .count          (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic v, input logic [7:0] d,
                               input logic [2:0] c, input logic f);
        chk({tag, ".valid"}, 32'(data_out_valid), 32'(v));
        chk({tag, ".data"},  32'(data_out),       32'(d));
        chk({tag, ".count"}, 32'(count),          32'(c));
        chk({tag, ".full"},  32'(full),           32'(f));
    endtask

    // Reference: a plain queue. Full/valid are judged on the state before the edge.
    task automatic model_step(input logic p, input logic [7:0] d, input logic po, input logic fl);
        bit was_full;
        bit was_valid;
        was_full  = (model_q.size() == DEPTH);
        was_valid = (model_q.size() != 0);
        if (fl) begin
            model_q.delete();
        end else begin
            if (po && was_valid) void'(model_q.pop_front());
            if (p && !was_full) model_q.push_back(d);
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] exp_d;
        exp_d = (model_q.size() != 0) ? model_q[0] : 8'h00;
        chk_outputs(tag, model_q.size() != 0, exp_d, 3'(model_q.size()),
                    model_q.size() == DEPTH);
    endtask

    task automatic cycle(input logic p, input logic [7:0] d, input logic po, input logic fl);
        push    = p;
        data_in = d;
        pop     = po;
        flush   = fl;
        @(posedge clk);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic wrap_cycle(input logic p, input logic [7:0] d, input logic po);
        if (po) popped.push_back(data_out);
        model_step(p, d, po, 1'b0);
        cycle(p, d, po, 1'b0);
        check_model("wrap");
        chk("wrap.count_le_depth", 32'(count <= 3'd4), 32'd1);
    endtask

    initial begin
        rst     = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        data_in = '0;

        // {push, din, pop, flush, exp_valid, exp_dout, exp_count, exp_full}
        // Fill and overflow, then drain.
        vecs.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 1'b0});
        vecs.push_back('{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 3'd2, 1'b0});
        vecs.push_back('{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 3'd3, 1'b0});
        vecs.push_back('{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1});
        vecs.push_back('{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 3'd3, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 3'd2, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0});
        // Show-ahead, push+pop, push+pop on empty.
        vecs.push_back('{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 8'hA1, 3'd1, 1'b0});
        vecs.push_back('{1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 8'hA2, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0});
        vecs.push_back('{1'b1, 8'hB5, 1'b1, 1'b0, 1'b1, 8'hB5, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0});
        // Full with push+pop: push rejected, pop taken.
        vecs.push_back('{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 3'd1, 1'b0});
        vecs.push_back('{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 3'd2, 1'b0});
        vecs.push_back('{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 3'd3, 1'b0});
        vecs.push_back('{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4, 1'b1});
        vecs.push_back('{1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 8'h02, 3'd3, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 3'd2, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h04, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0});
        // Flush beats push and pop.
        vecs.push_back('{1'b1, 8'h61, 1'b0, 1'b0, 1'b1, 8'h61, 3'd1, 1'b0});
        vecs.push_back('{1'b1, 8'h62, 1'b0, 1'b0, 1'b1, 8'h61, 3'd2, 1'b0});
        vecs.push_back('{1'b1, 8'h63, 1'b0, 1'b0, 1'b1, 8'h61, 3'd3, 1'b0});
        vecs.push_back('{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0});
        vecs.push_back('{1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 8'h88, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0});

        // Reset values are visible while rst is low, before any clock edge.
        #1;
        chk_outputs("reset", 1'b0, 8'h00, 3'd0, 1'b0);
        #11;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Load two entries, then reset asynchronously in mid-cycle.
        cycle(1'b1, 8'hC1, 1'b0, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0, 1'b0);
        chk_outputs("pre_reset", 1'b1, 8'hC1, 3'd2, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        chk_outputs("async_reset", 1'b0, 8'h00, 3'd0, 1'b0);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            chk_outputs($sformatf("idle%0d", i), 1'b0, 8'h00, 3'd0, 1'b0);
        end

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].push, vecs[i].din, vecs[i].pop, vecs[i].flush);
            chk_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_dout,
                        vecs[i].exp_count, vecs[i].exp_full);
        end

        // Wrap-around: 10 staggered push/pop pairs, pointers wrap twice.
        model_q.delete();
        wrap_cycle(1'b1, 8'h00, 1'b0);
        wrap_cycle(1'b1, 8'h01, 1'b0);
        for (int i = 2; i < 10; i++) begin
            wrap_cycle(1'b1, 8'(i), 1'b1);
        end
        wrap_cycle(1'b0, 8'h00, 1'b1);
        wrap_cycle(1'b0, 8'h00, 1'b1);
        chk("wrap.popped_count", 32'(popped.size()), 32'd10);
        for (int k = 0; k < 10 && k < popped.size(); k++) begin
            chk($sformatf("wrap.popped%0d", k), 32'(popped[k]), 32'(k));
        end

        // Randomised traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            logic       p;
            logic       po;
            logic       fl;
            logic [7:0] d;
            p  = ($urandom_range(0, 99) < 60);
            po = ($urandom_range(0, 99) < 55);
            fl = ($urandom_range(0, 99) < 4);
            d  = 8'($urandom);
            model_step(p, d, po, fl);
            cycle(p, d, po, fl);
            check_model($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
